// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: 8N1 UART receiver with button/mode command decode
module uart_cmd_ctrl #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 9600,
  parameter int OVS    = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  output logic [7:0] rx_byte_o,
  output logic       rx_done_o,
  output logic       frame_err_o,
  output logic       cmd_btn_r_o,
  output logic       cmd_btn_l_o,
  output logic       cmd_btn_u_o,
  output logic       cmd_btn_d_o,
  output logic [1:0] mode_sel_o,
  output logic       mode_valid_o,
  output logic       cmd_unknown_o
);
  localparam int DIV = CLK_HZ / (BAUD * OVS);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [3:0] MID = 4'(OVS / 2 - 1);
  localparam logic [3:0] LAST = 4'(OVS - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
  state_e state_q, state_d;
  logic s1_q, s2_q, rx_s;
  logic [DW-1:0] div_q, div_d;
  logic tick, start_go, samp_mid, samp_end, stop_ok, stop_bad;
  logic [3:0] tc_q, tc_d;
  logic [2:0] bi_q, bi_d;
  logic [7:0] sh_q, sh_d;
  logic arm_q, arm_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic rx_done_q, rx_done_d, frame_err_q, frame_err_d;
  logic [4:0] cmd_q, cmd_d;
  logic [1:0] mode_sel_q, mode_sel_d;
  logic mode_valid_q, mode_valid_d;
  logic is_r, is_l, is_u, is_d, is_mode;
  assign rx_s = s2_q;
  assign tick = div_q == DW'(DIV - 1);
  assign start_go = state_q == IDLE && arm_q && !rx_s;
  assign samp_mid = tick && tc_q == MID;
  assign samp_end = tick && tc_q == LAST;
  // two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) {s2_q, s1_q} <= 2'b11;
    else {s2_q, s1_q} <= {s1_q, rx_i};
  end
  // frame state and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      div_q   <= '0;
      tc_q    <= '0;
      bi_q    <= '0;
      sh_q    <= '0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tc_q    <= tc_d;
      bi_q    <= bi_d;
      sh_q    <= sh_d;
      arm_q   <= arm_d;
    end
  end
  // next frame state; start is re-checked mid-bit to reject glitches
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = start_go ? START : IDLE;
      START:   state_d = samp_mid ? (rx_s ? IDLE : DATA) : START;
      DATA:    state_d = (samp_end && bi_q == 3'd7) ? STOP : DATA;
      STOP:    state_d = samp_end ? IDLE : STOP;
      default: state_d = IDLE;
    endcase
  end
  // tick phase is realigned to the start edge; tc wraps every bit in DATA
  always_comb begin
    div_d = (start_go || tick) ? '0 : div_q + DW'(1);
    tc_d  = (state_q == IDLE || (state_q == START && samp_mid)) ? 4'd0 : tc_q + 4'(tick);
    bi_d  = state_q != DATA ? 3'd0 : samp_end ? bi_q + 3'd1 : bi_q;
    sh_d  = (state_q == DATA && samp_end) ? {rx_s, sh_q[7:1]} : sh_q;
    arm_d = stop_bad ? 1'b0 : (state_q == IDLE && rx_s) ? 1'b1 : arm_q;
  end
  // stop-bit verdicts; a low stop disarms so a break reports only once
  always_comb begin
    stop_ok  = state_q == STOP && samp_end && rx_s;
    stop_bad = state_q == STOP && samp_end && !rx_s;
  end
  // command classification of the held byte
  always_comb begin
    is_r    = rx_byte_q == 8'h52 || rx_byte_q == 8'h72;
    is_l    = rx_byte_q == 8'h4C || rx_byte_q == 8'h6C;
    is_u    = rx_byte_q == 8'h55 || rx_byte_q == 8'h75;
    is_d    = rx_byte_q == 8'h44 || rx_byte_q == 8'h64;
    is_mode = rx_byte_q >= 8'h30 && rx_byte_q <= 8'h32;
  end
  // output next-state: byte load on good stop, decode one cycle after rx_done
  always_comb begin
    rx_byte_d    = stop_ok ? sh_q : rx_byte_q;
    rx_done_d    = stop_ok;
    frame_err_d  = stop_bad;
    cmd_d        = rx_done_q ? {!(is_r || is_l || is_u || is_d || is_mode), is_d, is_u, is_l, is_r} : 5'd0;
    mode_sel_d   = (rx_done_q && is_mode) ? rx_byte_q[1:0] : mode_sel_q;
    mode_valid_d = mode_valid_q || (rx_done_q && is_mode);
  end
  // output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_byte_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      cmd_q        <= '0;
      mode_sel_q   <= '0;
      mode_valid_q <= 1'b0;
    end else begin
      rx_byte_q    <= rx_byte_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      cmd_q        <= cmd_d;
      mode_sel_q   <= mode_sel_d;
      mode_valid_q <= mode_valid_d;
    end
  end
  assign rx_byte_o     = rx_byte_q;
  assign rx_done_o     = rx_done_q;
  assign frame_err_o   = frame_err_q;
  assign cmd_btn_r_o   = cmd_q[0];
  assign cmd_btn_l_o   = cmd_q[1];
  assign cmd_btn_u_o   = cmd_q[2];
  assign cmd_btn_d_o   = cmd_q[3];
  assign cmd_unknown_o = cmd_q[4];
  assign mode_sel_o    = mode_sel_q;
  assign mode_valid_o  = mode_valid_q;
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed self-checking bench for uart_cmd_ctrl
module tb_uart_cmd_ctrl;
  localparam int BIT = 160;
  logic clk_i = 1'b0, rst_ni = 1'b0, rx_i = 1'b1;
  logic [7:0] rx_byte_o;
  logic rx_done_o, frame_err_o, cmd_btn_r_o, cmd_btn_l_o, cmd_btn_u_o, cmd_btn_d_o;
  logic [1:0] mode_sel_o;
  logic mode_valid_o, cmd_unknown_o;
  int n_cmp = 0, n_mis = 0;
  int cnt [7];
  int base [7];
  int width_bad = 0, lat_bad = 0, multi = 0;
  int ev_q [$];
  int qb;
  logic [6:0] vec, prev_vec = '0;
  uart_cmd_ctrl #(.CLK_HZ(1_600_000), .BAUD(10_000), .OVS(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_i(rx_i),
    .rx_byte_o(rx_byte_o), .rx_done_o(rx_done_o), .frame_err_o(frame_err_o),
    .cmd_btn_r_o(cmd_btn_r_o), .cmd_btn_l_o(cmd_btn_l_o),
    .cmd_btn_u_o(cmd_btn_u_o), .cmd_btn_d_o(cmd_btn_d_o),
    .mode_sel_o(mode_sel_o), .mode_valid_o(mode_valid_o), .cmd_unknown_o(cmd_unknown_o)
  );
  always #5 clk_i = ~clk_i;
  // pulse counting, width, latency and exclusivity monitor
  always @(negedge clk_i) begin
    vec = {rx_done_o, frame_err_o, cmd_btn_r_o, cmd_btn_l_o, cmd_btn_u_o, cmd_btn_d_o, cmd_unknown_o};
    if (rst_ni) begin
      width_bad += $countones(vec & prev_vec);
      if ($countones(vec[4:0]) > 1) multi++;
      if (|vec[4:0] && !prev_vec[6]) lat_bad++;
      for (int i = 0; i < 7; i++) if (vec[6-i]) cnt[i]++;
      for (int i = 2; i < 7; i++) if (vec[6-i]) ev_q.push_back(i);
    end
    prev_vec = vec;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic snap();
    base = cnt;
    qb = ev_q.size();
  endtask
  function automatic int dn(input int i);
    return cnt[i] - base[i];
  endfunction
  task automatic send_byte(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_i = f[i];
      repeat (BIT) @(negedge clk_i);
    end
  endtask
  task automatic idle(input int n);
    rx_i = 1'b1;
    repeat (n) @(negedge clk_i);
  endtask
  initial begin
    for (int i = 0; i < 7; i++) cnt[i] = 0;
    repeat (5) @(negedge clk_i);
    chk("rst_outputs", {rx_byte_o, rx_done_o, frame_err_o, cmd_btn_r_o, cmd_btn_l_o, cmd_btn_u_o, cmd_btn_d_o, mode_sel_o, mode_valid_o, cmd_unknown_o}, 0);
    rst_ni = 1'b1;
    idle(2 * BIT);
    snap();
    send_byte(8'h52, 1'b1);
    idle(2 * BIT);
    chk("R_done", dn(0), 1);
    chk("R_byte", rx_byte_o, 8'h52);
    chk("R_btn_r", dn(2), 1);
    chk("R_others", dn(1) + dn(3) + dn(4) + dn(5) + dn(6), 0);
    chk("R_width", width_bad, 0);
    chk("R_latency", lat_bad, 0);
    snap();
    send_byte(8'h31, 1'b1);
    idle(BIT);
    chk("m1_sel", mode_sel_o, 1);
    chk("m1_valid", mode_valid_o, 1);
    send_byte(8'h32, 1'b1);
    idle(BIT);
    chk("m2_sel", mode_sel_o, 2);
    chk("m2_valid", mode_valid_o, 1);
    chk("m_no_pulse", ev_q.size() - qb, 0);
    chk("m_done", dn(0), 2);
    snap();
    rx_i = 1'b0;
    repeat (50) @(negedge clk_i);
    idle(2 * BIT);
    chk("glitch_done", dn(0), 0);
    chk("glitch_ferr", dn(1), 0);
    send_byte(8'h75, 1'b1);
    idle(2 * BIT);
    chk("glitch_u", dn(4), 1);
    chk("glitch_byte", rx_byte_o, 8'h75);
    snap();
    send_byte(8'h41, 1'b0);
    rx_i = 1'b0;
    repeat (30 * BIT) @(negedge clk_i);
    idle(2 * BIT);
    chk("brk_ferr", dn(1), 1);
    chk("brk_done", dn(0), 0);
    chk("brk_unk", dn(6), 0);
    chk("brk_byte", rx_byte_o, 8'h75);
    send_byte(8'h64, 1'b1);
    idle(2 * BIT);
    chk("brk_d", dn(5), 1);
    chk("brk_byte_d", rx_byte_o, 8'h64);
    snap();
    rx_i = 1'b0;
    repeat (BIT) @(negedge clk_i);
    rx_i = 1'b1;
    repeat (BIT) @(negedge clk_i);
    rx_i = 1'b0;
    repeat (BIT + BIT / 2) @(negedge clk_i);
    rst_ni = 1'b0;
    rx_i = 1'b1;
    repeat (10) @(negedge clk_i);
    chk("abort_rst_byte", rx_byte_o, 0);
    chk("abort_rst_mode", {mode_sel_o, mode_valid_o}, 0);
    rst_ni = 1'b1;
    idle(12 * BIT);
    chk("abort_no_done", dn(0) + dn(1), 0);
    send_byte(8'h4C, 1'b1);
    idle(2 * BIT);
    chk("abort_l", dn(3), 1);
    chk("abort_valid", mode_valid_o, 0);
    chk("abort_total", ev_q.size() - qb, 1);
    snap();
    send_byte(8'h75, 1'b1);
    send_byte(8'h64, 1'b1);
    send_byte(8'h78, 1'b1);
    idle(2 * BIT);
    chk("b2b_count", ev_q.size() - qb, 3);
    chk("b2b_ev0", ev_q.size() > qb ? ev_q[qb] : 0, 4);
    chk("b2b_ev1", ev_q.size() > qb + 1 ? ev_q[qb+1] : 0, 5);
    chk("b2b_ev2", ev_q.size() > qb + 2 ? ev_q[qb+2] : 0, 6);
    chk("b2b_byte", rx_byte_o, 8'h78);
    chk("b2b_done", dn(0), 3);
    chk("all_width", width_bad, 0);
    chk("all_latency", lat_bad, 0);
    chk("all_exclusive", multi, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
